// File: rtl/field_extreme_scanner_if.sv
// Request/result bundle for field_extreme_scanner.
// The requester drives the operands and START; the scanner returns the result and status.
interface field_extreme_scanner_if #(
    parameter int unsigned W = 2,
    parameter int unsigned N = 4
);
    localparam int unsigned IW = $clog2(N);

    logic            START;
    logic            MODE;
    logic            MIN;
    logic [N*W-1:0]  X;
    logic [IW-1:0]   SEL1;
    logic [IW-1:0]   SEL2;
    logic [W-1:0]    Y;
    logic [IW-1:0]   IDX;
    logic            E;
    logic            BUSY;
    logic            DONE;

    modport master (
        output START, MODE, MIN, X, SEL1, SEL2,
        input  Y, IDX, E, BUSY, DONE
    );

    modport slave (
        input  START, MODE, MIN, X, SEL1, SEL2,
        output Y, IDX, E, BUSY, DONE
    );
endinterface

// File: rtl/field_extreme_scanner.sv
// Sequential max/min finder over a latched packed vector of N fields, one field per clock.
// Full mode scans every field; pair mode compares the two selected fields only.
module field_extreme_scanner #(
    parameter int unsigned W = 2,
    parameter int unsigned N = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    field_extreme_scanner_if.slave  bus
);
    localparam int unsigned IW = $clog2(N);

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

    state_t          state, state_nxt;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;

    logic [N*W-1:0]  x_q;
    logic            mode_q;
    logic            min_q;
    logic [IW-1:0]   sel1_q, sel2_q;
    logic [IW-1:0]   cnt;

    logic [W-1:0]    best, best_nxt;
    logic [IW-1:0]   bidx, bidx_nxt;
    logic            tie, tie_nxt;

    logic [W-1:0]    y_q;
    logic [IW-1:0]   idx_q;
    logic            e_q;

    logic [IW-1:0]   elem_idx;
    logic [W-1:0]    elem_val;
    logic            last;
    logic            better;

    // State register plus registered status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.START) state_nxt = SCAN;
            SCAN:    if (last)      state_nxt = FIN;
            FIN:                    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Status flags are computed from the upcoming state so they are valid straight from a flop
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (state_nxt != IDLE) busy_nxt = 1'b1;
        if (state_nxt == FIN)  done_nxt = 1'b1;
    end

    // Element selection; selectors beyond N-1 match no field and read as zero
    always_comb begin
        elem_idx = cnt;
        if (mode_q) elem_idx = (cnt == '0) ? sel1_q : sel2_q;
        elem_val = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (elem_idx == IW'(k)) elem_val = x_q[k*W +: W];
        end
        last = mode_q ? (cnt == IW'(1)) : (cnt == IW'(N - 1));
    end

    // Running extreme; ties keep the earliest index in scan order
    always_comb begin
        best_nxt = best;
        bidx_nxt = bidx;
        tie_nxt  = tie;
        better   = min_q ? (elem_val < best) : (elem_val > best);
        if (cnt == '0 || better) begin
            best_nxt = elem_val;
            bidx_nxt = elem_idx;
            tie_nxt  = 1'b0;
        end else if (elem_val == best) begin
            tie_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_q    <= '0;
            mode_q <= 1'b0;
            min_q  <= 1'b0;
            sel1_q <= '0;
            sel2_q <= '0;
            cnt    <= '0;
            best   <= '0;
            bidx   <= '0;
            tie    <= 1'b0;
            y_q    <= '0;
            idx_q  <= '0;
            e_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.START) begin
                x_q    <= bus.X;
                mode_q <= bus.MODE;
                min_q  <= bus.MIN;
                sel1_q <= bus.SEL1;
                sel2_q <= bus.SEL2;
                cnt    <= '0;
            end
        end else if (state == SCAN) begin
            best <= best_nxt;
            bidx <= bidx_nxt;
            tie  <= tie_nxt;
            cnt  <= cnt + IW'(1);
            if (last) begin
                y_q   <= best_nxt;
                idx_q <= bidx_nxt;
                e_q   <= tie_nxt;
            end
        end
    end

    assign bus.Y    = y_q;
    assign bus.IDX  = idx_q;
    assign bus.E    = e_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: doc/field_extreme_scanner.md
Name: field_extreme_scanner

Overview:
- Sequential, parametrised successor to the two-field 2-bit max selector.
- Latches an N-field packed word and scans it one field per clock.
- Reports the extreme value (max or min), the index where it occurs, and a tie flag.
- Two modes:
  - Full-scan: all N fields are compared.
  - Pair: only the two fields addressed by SEL1/SEL2 are compared.
- Used wherever the datapath needs a ranked pick from a packed vector without a wide combinational comparator tree.

Parameters:
- W, 2: width of one field, in bits (>=1).
- N, 4: number of fields in X (>=2).
- IW, $clog2(N): index width. Derived; not to be overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request pulse. Sampled only in IDLE.
- MODE  input  1  0 = full scan, 1 = pair compare. Latched with START.
- MIN  input  1  0 = find maximum, 1 = find minimum. Latched with START.
- X  input  N*W  packed fields. Field k = X[k*W+W-1 : k*W]. Latched with START.
- SEL1  input  IW  first field index for pair mode. Latched with START.
- SEL2  input  IW  second field index for pair mode. Latched with START.
- Y  output  W  extreme value of the last completed operation.
- IDX  output  IW  field index of Y.
- E  output  1  1 if two or more scanned elements equal the extreme value.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse marking that Y/IDX/E were just updated.

Behaviour:
- Reset:
  - RST high forces, immediately and asynchronously: state=IDLE, Y=0, IDX=0, E=0, BUSY=0, DONE=0, scan counter=0, latched operands=0.
  - Reset mid-scan aborts the operation. No DONE is produced.
- State machine:
  - IDLE: START=1 at an edge latches X, MODE, MIN, SEL1, SEL2; clears the counter; goes to SCAN.
  - SCAN: one element processed per edge. The edge that processes the last element goes to FIN.
  - FIN: DONE=1 for exactly one cycle, then IDLE on the next edge.
- BUSY=1 in SCAN and FIN, 0 in IDLE.
- Scan sequence, L elements:
  - Full mode: fields 0,1,...,N-1 (L=N).
  - Pair mode: field SEL1, then field SEL2 (L=2).
- Latency: START sampled at edge t → DONE high during the cycle following edge t+L.
  - Full mode with default N: DONE 4 cycles after the START edge.
  - Pair mode: DONE 2 cycles after the START edge.
- Comparison rules:
  - All comparisons are unsigned, W bits.
  - The first element initialises best=value, bidx=index, tie=0.
  - A later element strictly better than best (greater for max, less for min) replaces best and bidx, and sets tie=0.
  - A later element equal to best sets tie=1 and keeps bidx. The earliest element in scan order wins ties.
- Outputs:
  - Y/IDX/E are loaded from best/bidx/tie at the edge entering FIN.
  - They hold that value until the next FIN or reset. They are stable while BUSY.
- Pair mode with SEL1==SEL2: the same field is compared with itself, giving Y=that field, IDX=SEL1, E=1.
- Out-of-range selectors (SEL >= N, possible when N is not a power of 2): the field reads as 0, and IDX reports the raw SEL value.
- START while BUSY (SCAN or FIN) is ignored. It is not queued.
- START in the cycle where DONE is high is also ignored. A new request is accepted only from IDLE.
- Input changes on X/SEL/MODE/MIN after the START edge have no effect on the running operation.

Test Plan (W=2, N=4):
- Reset: RST=1 asserted mid-cycle → Y=0, IDX=0, E=0, BUSY=0, DONE=0 immediately, without waiting for a CLK edge.
- Full max, X=8'b11_01_10_00, MODE=0, MIN=0 → BUSY for 5 cycles; DONE 4 cycles after the START edge; Y=3, IDX=3, E=0.
- Full min, same X, MIN=1 → Y=0, IDX=0, E=0.
- Full max with tie, X=8'b10_00_10_01 → Y=2, IDX=1, E=1.
- Pair mode, X=8'b11_01_10_00, MIN=0:
  - SEL1=1, SEL2=2 → DONE 2 cycles after START; Y=2, IDX=1, E=0.
  - SEL1=SEL2=2 → Y=1, IDX=2, E=1.
- Robustness:
  - START re-pulsed during SCAN with a different X → ignored; result matches the first X.
  - RST pulsed during SCAN → no DONE; outputs return to 0; a following START runs normally.
